pipe_skid_stage: RTL



---
 rtl/pipe_skid_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a main + skid register pair.
// Outputs decode straight from flops, so M_READY never reaches S_READY combinationally.
module pipe_skid_stage #(
    parameter int W = 9
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         FLUSH,
    input  logic         S_VALID,
    output logic         S_READY,
    input  logic [W-1:0] S_DATA,
    output logic         M_VALID,
    input  logic         M_READY,
    output logic [W-1:0] M_DATA,
    output logic [1:0]   OCC
);

    // Encoding doubles as the occupancy count presented on OCC.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           accept_s;
    logic           take_s;

    // Handshake events as seen at the coming edge.
    always_comb begin
        accept_s = S_VALID & (state_q != ST_FULL);
        take_s   = M_READY & (state_q != ST_EMPTY);
    end

    // Next-state and datapath; a flush drops everything, including this cycle's transfers.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = S_DATA;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && take_s) begin
                        main_d = S_DATA;
                    end else if (accept_s) begin
                        state_d = ST_FULL;
                        skid_d  = S_DATA;
                    end else if (take_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            main_q  <= {W{1'b0}};
            skid_q  <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        M_VALID = (state_q != ST_EMPTY);
        S_READY = (state_q != ST_FULL);
        M_DATA  = main_q;
        OCC     = state_q;
    end

endmodule
